// File: rtl/mem_req_agent_pkg.sv
// Shared definitions for the shared-RAM request agent: FSM encodings, default widths and
// the counter-width helper used by the agent and the memory controllers.
package mem_req_agent_pkg;

    localparam int unsigned DefAw = 8;
    localparam int unsigned DefDw = 8;

    typedef enum logic [1:0] {
        MraIdle = 2'd0,
        MraReq  = 2'd1,
        MraWait = 2'd2,
        MraResp = 2'd3
    } mra_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Loadable counter with saturating increment and decrement; used for the read-latency
// countdown and for the request timeout count.
module mem_req_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_req_agent.sv
// Core-side initiator for the shared-RAM arbitration protocol: holds rden/wren until acq,
// absorbs read latency and returns one response per command. Optional abort: MEM_REQ_TIMEOUT_EN.
module mem_req_agent
    import mem_req_agent_pkg::*;
#(
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rden,
    output logic          wren,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] Din,
    input  logic          acq,
    input  logic [DW-1:0] Dq,
    output logic          busy
);

    localparam int unsigned LatW = cnt_width(RD_LAT);

    mra_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic          rden_q, rden_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic            lat_load;
    logic            lat_dec;
    logic [LatW-1:0] lat_cnt;

    mem_req_timer #(
        .W (LatW)
    ) u_lat_timer (
        .clk      (CLK),
        .rst      (rst),
        .load     (lat_load),
        .load_val (LatW'(RD_LAT)),
        .inc      (1'b0),
        .dec      (lat_dec),
        .cnt      (lat_cnt)
    );

`ifdef MEM_REQ_TIMEOUT_EN
    logic       err_q, err_d;
    logic       to_clr;
    logic       to_inc;
    logic [7:0] to_cnt;
    logic       to_done;

    mem_req_timer #(
        .W (8)
    ) u_to_timer (
        .clk      (CLK),
        .rst      (rst),
        .load     (to_clr),
        .load_val (8'd0),
        .inc      (to_inc),
        .dec      (1'b0),
        .cnt      (to_cnt)
    );

    // to_cnt holds completed REQ cycles, so this is the TIMEOUT-th REQ cycle.
    assign to_done = (to_cnt == 8'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        rden_d   = rden_q;
        wren_d   = wren_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
        err_d    = err_q;
        to_clr   = 1'b0;
        to_inc   = 1'b0;
`endif
        unique case (state_q)
            MraIdle: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    din_d   = cmd_wdata;
                    rden_d  = ~cmd_we;
                    wren_d  = cmd_we;
                    state_d = MraReq;
`ifdef MEM_REQ_TIMEOUT_EN
                    err_d   = 1'b0;
                    to_clr  = 1'b1;
`endif
                end
            end
            MraReq: begin
`ifdef MEM_REQ_TIMEOUT_EN
                to_inc = 1'b1;
`endif
                if (acq) begin
                    rden_d = 1'b0;
                    wren_d = 1'b0;
                    if (we_q) begin
                        state_d = MraResp;
                    end else if (RD_LAT == 0) begin
                        rdata_d = Dq;
                        state_d = MraResp;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = MraWait;
                    end
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (to_done) begin
                    rden_d  = 1'b0;
                    wren_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = MraResp;
                end
`endif
            end
            MraWait: begin
                lat_dec = 1'b1;
                if (lat_cnt == LatW'(1)) begin
                    rdata_d = Dq;
                    state_d = MraResp;
                end
            end
            MraResp: begin
                state_d = MraIdle;
            end
            default: begin
                state_d = MraIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= MraIdle;
            we_q    <= 1'b0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
`ifdef MEM_REQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == MraIdle);
    assign busy      = (state_q != MraIdle);
    assign rsp_valid = (state_q == MraResp);
    assign rsp_rdata = rdata_q;
    assign rden      = rden_q;
    assign wren      = wren_q;
    assign Address   = addr_q;
    assign Din       = din_q;

`ifdef MEM_REQ_TIMEOUT_EN
    assign rsp_err = (state_q == MraResp) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_agent.sv
// Directed self-checking bench for mem_req_agent (RD_LAT=1, TIMEOUT=4); the abort scenario
// runs only when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_req_agent;

    logic       CLK = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rden;
    logic       wren;
    logic [7:0] Address;
    logic [7:0] Din;
    logic       acq;
    logic [7:0] Dq;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mem_req_agent #(
        .AW      (8),
        .DW      (8),
        .RD_LAT  (1),
        .TIMEOUT (4)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rden      (rden),
        .wren      (wren),
        .Address   (Address),
        .Din       (Din),
        .acq       (acq),
        .Dq        (Dq),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        acq = 1'b0; Dq = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_ready", cmd_ready, 1);
        check("rst_rden", rden, 0);
        check("rst_wren", wren, 0);
        check("rst_addr", Address, 0);
        check("rst_din", Din, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);

        // 1: load 0x10, immediate grant, data A5
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h10;
        step();
        cmd_valid = 1'b0; acq = 1'b1;
        check("t1_rden", rden, 1);
        check("t1_wren", wren, 0);
        check("t1_addr", Address, 8'h10);
        check("t1_busy", busy, 1);
        check("t1_ready", cmd_ready, 0);
        step();
        acq = 1'b0; Dq = 8'hA5;
        check("t1_rden_drop", rden, 0);
        check("t1_no_rsp_wait", rsp_valid, 0);
        step();
        Dq = 8'h00;
        check("t1_rvalid", rsp_valid, 1);
        check("t1_rdata", rsp_rdata, 8'hA5);
        check("t1_err", rsp_err, 0);
        check("t1_ready_resp", cmd_ready, 0);
        step();
        check("t1_rvalid_pulse", rsp_valid, 0);
        check("t1_ready_idle", cmd_ready, 1);
        check("t1_rdata_hold", rsp_rdata, 8'hA5);

        // 2: store 0x22/0x3C, grant on 6th REQ cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h22; cmd_wdata = 8'h3C;
        step();
        cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            check("t2_wren", wren, 1);
            check("t2_rden", rden, 0);
            check("t2_addr", Address, 8'h22);
            check("t2_din", Din, 8'h3C);
            check("t2_busy", busy, 1);
            check("t2_no_rsp", rsp_valid, 0);
            if (i == 5) acq = 1'b1;
            step();
        end
        acq = 1'b0;
        check("t2_rvalid", rsp_valid, 1);
        check("t2_err", rsp_err, 0);
        check("t2_wren_drop", wren, 0);
        check("t2_busy_resp", busy, 1);
        step();
        check("t2_rvalid_pulse", rsp_valid, 0);
        check("t2_busy_idle", busy, 0);
        check("t2_rdata_keep", rsp_rdata, 8'hA5);

        // 3: back-to-back loads 0x01 then 0x02 with cmd_valid held
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h01;
        step();
        acq = 1'b1; cmd_addr = 8'h02;
        check("t3a_rden", rden, 1);
        check("t3a_addr", Address, 8'h01);
        step();
        acq = 1'b0; Dq = 8'h11;
        check("t3a_ready_wait", cmd_ready, 0);
        step();
        Dq = 8'h00;
        check("t3a_rvalid", rsp_valid, 1);
        check("t3a_rdata", rsp_rdata, 8'h11);
        check("t3a_ready_resp", cmd_ready, 0);
        step();
        check("t3_ready_after", cmd_ready, 1);
        check("t3_rvalid_low", rsp_valid, 0);
        step();
        cmd_valid = 1'b0; acq = 1'b1;
        check("t3b_rden", rden, 1);
        check("t3b_addr", Address, 8'h02);
        step();
        acq = 1'b0; Dq = 8'h22;
        step();
        Dq = 8'h00;
        check("t3b_rvalid", rsp_valid, 1);
        check("t3b_rdata", rsp_rdata, 8'h22);
        step();

        // 4: reset while in WAIT
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h30;
        step();
        cmd_valid = 1'b0; acq = 1'b1;
        step();
        acq = 1'b0;
        check("t4_busy_wait", busy, 1);
        rst = 1'b1; Dq = 8'h77;
        step();
        check("t4_rden", rden, 0);
        check("t4_wren", wren, 0);
        check("t4_busy", busy, 0);
        check("t4_rvalid", rsp_valid, 0);
        check("t4_ready", cmd_ready, 1);
        check("t4_rdata", rsp_rdata, 0);
        rst = 1'b0;
        step();
        check("t4_no_late_rsp", rsp_valid, 0);
        check("t4_addr_clr", Address, 0);

        // 5: spurious acq in IDLE and WAIT, Dq toggling outside the capture edge
        acq = 1'b1; Dq = 8'h5A;
        step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_rden", rden, 0);
        check("t5_idle_rvalid", rsp_valid, 0);
        check("t5_idle_rdata", rsp_rdata, 0);
        acq = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h40;
        step();
        cmd_valid = 1'b0; acq = 1'b1; Dq = 8'hEE;
        step();
        Dq = 8'h3C;
        check("t5_wait_rden", rden, 0);
        step();
        acq = 1'b0; Dq = 8'hFF;
        check("t5_rvalid", rsp_valid, 1);
        check("t5_rdata", rsp_rdata, 8'h3C);
        step();
        Dq = 8'h00;
        check("t5_idle_after", busy, 0);
        step();
        check("t5_rdata_hold", rsp_rdata, 8'h3C);

`ifdef MEM_REQ_TIMEOUT_EN
        // 6a: load with no grant aborts after 4 REQ cycles
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h50;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6a_rden", rden, 1);
            check("t6a_no_rsp", rsp_valid, 0);
            step();
        end
        check("t6a_rvalid", rsp_valid, 1);
        check("t6a_err", rsp_err, 1);
        check("t6a_rden_drop", rden, 0);
        check("t6a_rdata", rsp_rdata, 8'h3C);
        step();
        check("t6a_err_pulse", rsp_err, 0);

        // 6b: store granted on 4th REQ cycle; grant beats timeout
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h60; cmd_wdata = 8'h99;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6b_wren", wren, 1);
            if (i == 3) acq = 1'b1;
            step();
        end
        acq = 1'b0;
        check("t6b_rvalid", rsp_valid, 1);
        check("t6b_err", rsp_err, 0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
